// File: rtl/hazard_controller_if.sv
// Sequencing bus between the MIPS datapath and the hazard controller.
// The datapath drives the ID-stage decode and branch outcome; the controller
// returns stall/flush/bubble controls and EX operand forwarding selects.
interface hazard_controller_if;
    logic       ID_VALID;
    logic [2:0] ID_IRJ;
    logic [4:0] ID_RS;
    logic [4:0] ID_RT;
    logic       ID_USE_RS;
    logic       ID_USE_RT;
    logic [4:0] ID_WREG;
    logic       ID_WEN;
    logic       ID_LOAD;
    logic       ID_MULDIV;
    logic       ID_HILO;
    logic       EX_BR_TAKEN;

    logic       STALL_IF;
    logic       STALL_ID;
    logic       BUBBLE_EX;
    logic       FLUSH_ID;
    logic [1:0] FWD_A;
    logic [1:0] FWD_B;
    logic       MULDIV_BUSY;

    // Datapath side
    modport master (
        output ID_VALID, ID_IRJ, ID_RS, ID_RT, ID_USE_RS, ID_USE_RT,
               ID_WREG, ID_WEN, ID_LOAD, ID_MULDIV, ID_HILO, EX_BR_TAKEN,
        input  STALL_IF, STALL_ID, BUBBLE_EX, FLUSH_ID, FWD_A, FWD_B, MULDIV_BUSY
    );

    // Controller side
    modport slave (
        input  ID_VALID, ID_IRJ, ID_RS, ID_RT, ID_USE_RS, ID_USE_RT,
               ID_WREG, ID_WEN, ID_LOAD, ID_MULDIV, ID_HILO, EX_BR_TAKEN,
        output STALL_IF, STALL_ID, BUBBLE_EX, FLUSH_ID, FWD_A, FWD_B, MULDIV_BUSY
    );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller for the 5-stage MIPS core.
// Tracks in-flight destinations (EX/MEM/WB) and the HI/LO mult/div occupancy,
// and produces stall/flush/bubble controls plus EX forwarding selects.
// Optional: define HAZARD_STALL_COUNT_EN to add the saturating STALL_CNT output.
module hazard_controller #(
    parameter int unsigned MULDIV_CYCLES = 4,
    parameter int unsigned CNT_W         = 16
) (
    input  logic              CLK,
    input  logic              RESET_N,
    hazard_controller_if.slave hz
`ifdef HAZARD_STALL_COUNT_EN
    ,
    output logic [CNT_W-1:0]  STALL_CNT
`endif
);

    localparam int unsigned REG_W = 5;
    localparam int unsigned MD_W  = 4;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             load;
    } sb_entry_t;

    sb_entry_t        ex_q, ex_d;
    sb_entry_t        mem_q, mem_d;
    sb_entry_t        wb_q, wb_d;
    logic [REG_W-1:0] ex_rs_q, ex_rs_d;
    logic [REG_W-1:0] ex_rt_q, ex_rt_d;
    logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
    logic             md_busy_q, md_busy_d;

    logic lu_c, hl_c, md_c, fl_c, stall_c, bubble_c;

    // Only the jump bit of the instruction class steers sequencing.
    logic unused_irj;
    assign unused_irj = |hz.ID_IRJ[2:1];

    function automatic logic is_writer(input sb_entry_t e);
        return e.valid && (e.rd != '0);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                           input sb_entry_t mem,
                                           input sb_entry_t wb);
        // A load result is not available in MEM; only ALU results forward from there.
        if (is_writer(mem) && !mem.load && (mem.rd == src)) begin
            return 2'b01;
        end
        if (is_writer(wb) && (wb.rd == src)) begin
            return 2'b10;
        end
        return 2'b00;
    endfunction

    // Hazard detection from current scoreboard and ID-stage decode
    always_comb begin
        lu_c = hz.ID_VALID && ex_q.load && is_writer(ex_q) &&
               ((hz.ID_USE_RS && (ex_q.rd == hz.ID_RS)) ||
                (hz.ID_USE_RT && (ex_q.rd == hz.ID_RT)));
        hl_c     = hz.ID_VALID && hz.ID_HILO   && (md_cnt_q != '0);
        md_c     = hz.ID_VALID && hz.ID_MULDIV && (md_cnt_q != '0);
        fl_c     = hz.EX_BR_TAKEN || (hz.ID_VALID && hz.ID_IRJ[0]);
        stall_c  = lu_c || hl_c || md_c;
        bubble_c = fl_c ? hz.EX_BR_TAKEN : stall_c;
    end

    // Sequencing outputs: a flush overrides any pending stall
    always_comb begin
        hz.STALL_IF  = 1'b0;
        hz.STALL_ID  = 1'b0;
        hz.FLUSH_ID  = 1'b0;
        hz.BUBBLE_EX = bubble_c;
        if (fl_c) begin
            hz.FLUSH_ID = 1'b1;
        end else if (stall_c) begin
            hz.STALL_IF = 1'b1;
            hz.STALL_ID = 1'b1;
        end
    end

    // Forwarding selects for the instruction currently in EX
    always_comb begin
        hz.FWD_A = fwd_sel(ex_rs_q, mem_q, wb_q);
        hz.FWD_B = fwd_sel(ex_rt_q, mem_q, wb_q);
    end

    assign hz.MULDIV_BUSY = md_busy_q;

    // Scoreboard advance and mult/div occupancy countdown
    always_comb begin
        mem_d    = ex_q;
        wb_d     = mem_q;
        ex_d     = '0;
        ex_rs_d  = '0;
        ex_rt_d  = '0;
        md_cnt_d = md_cnt_q;
        if (!bubble_c) begin
            ex_d.valid = hz.ID_VALID && hz.ID_WEN;
            ex_d.rd    = hz.ID_WREG;
            ex_d.load  = hz.ID_LOAD;
            ex_rs_d    = hz.ID_RS;
            ex_rt_d    = hz.ID_RT;
        end
        if (hz.ID_VALID && hz.ID_MULDIV && !bubble_c) begin
            md_cnt_d = MD_W'(MULDIV_CYCLES);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - MD_W'(1);
        end
        md_busy_d = (md_cnt_d != '0);
    end

    // State registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            ex_rs_q   <= '0;
            ex_rt_q   <= '0;
            md_cnt_q  <= '0;
            md_busy_q <= 1'b0;
        end else begin
            ex_q      <= ex_d;
            mem_q     <= mem_d;
            wb_q      <= wb_d;
            ex_rs_q   <= ex_rs_d;
            ex_rt_q   <= ex_rt_d;
            md_cnt_q  <= md_cnt_d;
            md_busy_q <= md_busy_d;
        end
    end

`ifdef HAZARD_STALL_COUNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of front-end stall cycles
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!fl_c && stall_c && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Stall counter register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign STALL_CNT = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Testbench for hazard_controller: directed pipeline scenarios followed by
// random instruction streams, all checked against a history-based pipeline model.
module tb_hazard_controller;

    localparam int unsigned MDC   = 4;
    localparam int unsigned CNT_W = 16;

    logic CLK;
    logic RESET_N;
    hazard_controller_if hz();
`ifdef HAZARD_STALL_COUNT_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

    hazard_controller #(.MULDIV_CYCLES(MDC), .CNT_W(CNT_W)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .hz      (hz)
`ifdef HAZARD_STALL_COUNT_EN
        ,
        .STALL_CNT (stall_cnt)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct packed {
        logic       valid;
        logic [2:0] irj;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic [4:0] wreg;
        logic       wen;
        logic       load;
        logic       muldiv;
        logic       hilo;
    } instr_t;

    // What entered EX on a given edge (all-zero for a bubble)
    typedef struct packed {
        logic       wen;
        logic [4:0] wreg;
        logic       load;
        logic [4:0] rs;
        logic [4:0] rt;
    } flight_t;

    flight_t     hist[$];      // hist[0] in EX, hist[1] in MEM, hist[2] in WB
    int          edges;
    int          last_md;
    bit          have_md;
    int          stalls;

    int errors = 0;
    int checks = 0;

    logic       e_stall, e_bubble, e_flush, e_busy;
    logic [1:0] e_fwd_a, e_fwd_b;
    logic       o_stall, o_stall_id, o_bubble, o_flush, o_busy;
    logic [1:0] o_fwd_a, o_fwd_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic instr_t i_nop();
        instr_t i = '0;
        return i;
    endfunction

    function automatic instr_t i_alu(input int rd, input int rs, input int rt);
        instr_t i = '0;
        i.valid = 1'b1; i.irj = 3'b010;
        i.rs = 5'(rs); i.rt = 5'(rt); i.use_rs = 1'b1; i.use_rt = 1'b1;
        i.wreg = 5'(rd); i.wen = 1'b1;
        return i;
    endfunction

    function automatic instr_t i_lw(input int rt, input int base);
        instr_t i = '0;
        i.valid = 1'b1; i.irj = 3'b100;
        i.rs = 5'(base); i.use_rs = 1'b1; i.rt = 5'(rt);
        i.wreg = 5'(rt); i.wen = 1'b1; i.load = 1'b1;
        return i;
    endfunction

    function automatic instr_t i_mult(input int rs, input int rt);
        instr_t i = '0;
        i.valid = 1'b1; i.irj = 3'b010;
        i.rs = 5'(rs); i.rt = 5'(rt); i.use_rs = 1'b1; i.use_rt = 1'b1;
        i.muldiv = 1'b1;
        return i;
    endfunction

    function automatic instr_t i_mfhi(input int rd);
        instr_t i = '0;
        i.valid = 1'b1; i.irj = 3'b010;
        i.wreg = 5'(rd); i.wen = 1'b1; i.hilo = 1'b1;
        return i;
    endfunction

    function automatic instr_t i_j();
        instr_t i = '0;
        i.valid = 1'b1; i.irj = 3'b001;
        return i;
    endfunction

    function automatic instr_t i_rand();
        instr_t i;
        int     a = int'($urandom_range(0, 3));
        int     b = int'($urandom_range(0, 3));
        int     c = int'($urandom_range(0, 3));
        case ($urandom_range(0, 6))
            0, 1:    i = i_alu(a, b, c);
            2:       i = i_lw(a, b);
            3:       i = i_mult(a, b);
            4:       i = i_mfhi(a);
            5:       i = i_j();
            default: begin
                i = instr_t'($urandom);
                i.valid = 1'b0;
            end
        endcase
        if (i.valid && $urandom_range(0, 4) == 0) i.use_rt = 1'b0;
        return i;
    endfunction

    function automatic bit writes(input flight_t f);
        return f.wen && (f.wreg != 5'd0);
    endfunction

    function automatic logic [1:0] model_fwd(input logic [4:0] src, input flight_t mem, input flight_t wb);
        if (writes(mem) && !mem.load && mem.wreg == src) return 2'b01;
        if (writes(wb) && wb.wreg == src) return 2'b10;
        return 2'b00;
    endfunction

    function automatic int md_left();
        int age;
        if (!have_md) return 0;
        age = edges - last_md;
        return (age < int'(MDC)) ? int'(MDC) - age : 0;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < 3; k++) hist.push_back('0);
        edges   = 0;
        last_md = 0;
        have_md = 1'b0;
        stalls  = 0;
    endtask

    task automatic model_eval(input instr_t in, input logic br);
        flight_t ex  = hist[0];
        flight_t mem = hist[1];
        flight_t wb  = hist[2];
        bit lu, hl, mdh, fl, st;
        lu  = in.valid && ex.load && writes(ex) &&
              ((in.use_rs && ex.wreg == in.rs) || (in.use_rt && ex.wreg == in.rt));
        hl  = in.valid && in.hilo   && (md_left() > 0);
        mdh = in.valid && in.muldiv && (md_left() > 0);
        fl  = br || (in.valid && in.irj[0]);
        st  = lu || hl || mdh;
        e_flush  = fl;
        e_bubble = fl ? br : st;
        e_stall  = !fl && st;
        e_fwd_a  = model_fwd(ex.rs, mem, wb);
        e_fwd_b  = model_fwd(ex.rt, mem, wb);
        e_busy   = (md_left() > 0);
    endtask

    task automatic model_advance(input instr_t in);
        flight_t n = '0;
        if (!e_bubble) begin
            n.wen  = in.valid && in.wen;
            n.wreg = in.wreg;
            n.load = in.load;
            n.rs   = in.rs;
            n.rt   = in.rt;
        end
        hist.push_front(n);
        void'(hist.pop_back());
        edges++;
        if (in.valid && in.muldiv && !e_bubble) begin
            have_md = 1'b1;
            last_md = edges;
        end
        if (e_stall) stalls++;
    endtask

    task automatic apply(input instr_t in, input logic br);
        hz.ID_VALID    = in.valid;
        hz.ID_IRJ      = in.irj;
        hz.ID_RS       = in.rs;
        hz.ID_RT       = in.rt;
        hz.ID_USE_RS   = in.use_rs;
        hz.ID_USE_RT   = in.use_rt;
        hz.ID_WREG     = in.wreg;
        hz.ID_WEN      = in.wen;
        hz.ID_LOAD     = in.load;
        hz.ID_MULDIV   = in.muldiv;
        hz.ID_HILO     = in.hilo;
        hz.EX_BR_TAKEN = br;
    endtask

    // One clock: drive at posedge+1, compare at the falling edge, advance model at the rising edge
    task automatic step(input instr_t in, input logic br);
        apply(in, br);
        #4;
        model_eval(in, br);
        o_stall    = hz.STALL_IF;
        o_stall_id = hz.STALL_ID;
        o_bubble   = hz.BUBBLE_EX;
        o_flush    = hz.FLUSH_ID;
        o_busy     = hz.MULDIV_BUSY;
        o_fwd_a    = hz.FWD_A;
        o_fwd_b    = hz.FWD_B;
        chk("stall_if",    32'(o_stall),    32'(e_stall));
        chk("stall_id",    32'(o_stall_id), 32'(e_stall));
        chk("bubble_ex",   32'(o_bubble),   32'(e_bubble));
        chk("flush_id",    32'(o_flush),    32'(e_flush));
        chk("fwd_a",       32'(o_fwd_a),    32'(e_fwd_a));
        chk("fwd_b",       32'(o_fwd_b),    32'(e_fwd_b));
        chk("muldiv_busy", 32'(o_busy),     32'(e_busy));
`ifdef HAZARD_STALL_COUNT_EN
        chk("stall_cnt",   32'(stall_cnt),  (stalls > 65535) ? 32'd65535 : 32'(stalls));
`endif
        @(posedge CLK);
        model_advance(in);
        #1;
    endtask

    initial begin
        int k;
        RESET_N = 1'b0;
        apply(i_nop(), 1'b0);
        model_reset();

        // Reset state
        #12;
        chk("rst_stall_if",  32'(hz.STALL_IF),    32'd0);
        chk("rst_stall_id",  32'(hz.STALL_ID),    32'd0);
        chk("rst_bubble",    32'(hz.BUBBLE_EX),   32'd0);
        chk("rst_flush",     32'(hz.FLUSH_ID),    32'd0);
        chk("rst_fwd_a",     32'(hz.FWD_A),       32'd0);
        chk("rst_fwd_b",     32'(hz.FWD_B),       32'd0);
        chk("rst_busy",      32'(hz.MULDIV_BUSY), 32'd0);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;

        // Load-use: LW $8 ; ADD $9,$8,$1 -> one stall, then forward from WB
        step(i_lw(8, 1), 1'b0);
        chk("lu_lw_nostall", 32'(o_stall), 32'd0);
        step(i_alu(9, 8, 1), 1'b0);
        chk("lu_stall_if",   32'(o_stall),    32'd1);
        chk("lu_stall_id",   32'(o_stall_id), 32'd1);
        chk("lu_bubble",     32'(o_bubble),   32'd1);
        step(i_alu(9, 8, 1), 1'b0);
        chk("lu_released",   32'(o_stall), 32'd0);
        step(i_nop(), 1'b0);
        chk("lu_fwd_a_wb",   32'(o_fwd_a), 32'd2);
        chk("lu_fwd_b",      32'(o_fwd_b), 32'd0);

        // ALU forwarding, back-to-back then with one independent in between
        step(i_alu(3, 1, 2), 1'b0);
        step(i_alu(4, 3, 3), 1'b0);
        chk("alu_nostall",   32'(o_stall), 32'd0);
        step(i_nop(), 1'b0);
        chk("alu_fwd_a_mem", 32'(o_fwd_a), 32'd1);
        chk("alu_fwd_b_mem", 32'(o_fwd_b), 32'd1);
        step(i_alu(3, 1, 2), 1'b0);
        step(i_alu(7, 1, 2), 1'b0);
        step(i_alu(4, 3, 3), 1'b0);
        step(i_nop(), 1'b0);
        chk("alu_fwd_a_wb",  32'(o_fwd_a), 32'd2);
        chk("alu_fwd_b_wb",  32'(o_fwd_b), 32'd2);

        // Register 0 never stalls or forwards
        step(i_lw(0, 1), 1'b0);
        step(i_alu(5, 0, 0), 1'b0);
        chk("r0_nostall",    32'(o_stall), 32'd0);
        step(i_nop(), 1'b0);
        chk("r0_fwd_a",      32'(o_fwd_a), 32'd0);
        chk("r0_fwd_b",      32'(o_fwd_b), 32'd0);

        // MULT ; MFHI -> MFHI held for MULDIV_CYCLES cycles
        step(i_mult(1, 2), 1'b0);
        for (k = 0; k < 20; k++) begin
            step(i_mfhi(6), 1'b0);
            if (!o_stall) break;
            chk("md_stall_id",  32'(o_stall_id), 32'd1);
            chk("md_busy_held", 32'(o_busy),     32'd1);
        end
        chk("md_stall_cycles", 32'(k), 32'(MDC));
        chk("md_busy_release", 32'(o_busy), 32'd0);

        // Branch resolving taken while a load-use stall is pending
        step(i_lw(8, 1), 1'b0);
        step(i_alu(9, 8, 1), 1'b1);
        chk("br_flush",      32'(o_flush),  32'd1);
        chk("br_bubble",     32'(o_bubble), 32'd1);
        chk("br_stall_if",   32'(o_stall),  32'd0);
        step(i_j(), 1'b0);
        chk("j_flush",       32'(o_flush),  32'd1);
        chk("j_bubble",      32'(o_bubble), 32'd0);
        step(i_nop(), 1'b0);

        // Reset asserted during the second MFHI stall cycle
        step(i_mult(1, 2), 1'b0);
        step(i_mfhi(6), 1'b0);
        chk("rmid_stall1", 32'(o_stall), 32'd1);
        apply(i_mfhi(6), 1'b0);
        #1;
        chk("rmid_stall2_pre", 32'(hz.STALL_IF), 32'd1);
        #1;
        RESET_N = 1'b0;
        #1;
        chk("rmid_stall_if", 32'(hz.STALL_IF),    32'd0);
        chk("rmid_stall_id", 32'(hz.STALL_ID),    32'd0);
        chk("rmid_bubble",   32'(hz.BUBBLE_EX),   32'd0);
        chk("rmid_flush",    32'(hz.FLUSH_ID),    32'd0);
        chk("rmid_fwd_a",    32'(hz.FWD_A),       32'd0);
        chk("rmid_fwd_b",    32'(hz.FWD_B),       32'd0);
        chk("rmid_busy",     32'(hz.MULDIV_BUSY), 32'd0);
`ifdef HAZARD_STALL_COUNT_EN
        chk("rmid_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        model_reset();
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        step(i_mfhi(6), 1'b0);
        chk("rmid_no_residual", 32'(o_stall), 32'd0);

        // Random instruction streams against the model
        for (int n = 0; n < 400; n++) begin
            step(i_rand(), ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Takes the decoded ID-stage instruction class (IRJ one-hot: bit0 jump, bit1 SPECIAL/R-type, bit2 other) and register fields.
- Keeps a 3-entry scoreboard of in-flight destinations (EX/MEM/WB) and a HI/LO mult/div busy counter.
- Drives stall, flush, bubble and forwarding selects for the datapath.

Parameters:
- MULDIV_CYCLES, 4, EX-occupancy cycles of a mult/div before HI/LO is valid (legal range 1..15).
- CNT_W, 16, width of the optional stall counter.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- ID_VALID  in  1  ID stage holds a real instruction.
- ID_IRJ  in  3  instruction class, one-hot.
- ID_RS  in  5  source register A.
- ID_RT  in  5  source register B.
- ID_USE_RS  in  1  instruction reads RS.
- ID_USE_RT  in  1  instruction reads RT.
- ID_WREG  in  5  destination register (RD or RT, already muxed).
- ID_WEN  in  1  instruction writes ID_WREG.
- ID_LOAD  in  1  instruction is a load.
- ID_MULDIV  in  1  instruction is MULT/DIV and writes HI/LO.
- ID_HILO  in  1  instruction reads HI/LO (MFHI/MFLO).
- EX_BR_TAKEN  in  1  branch in EX resolved taken.
- STALL_IF  out  1  hold PC and IF/ID register.
- STALL_ID  out  1  hold the ID instruction.
- BUBBLE_EX  out  1  insert NOP into ID/EX.
- FLUSH_ID  out  1  kill the IF/ID contents.
- FWD_A  out  2  EX operand A select: 00 register file, 01 MEM result, 10 WB result.
- FWD_B  out  2  EX operand B select, same encoding as FWD_A.
- MULDIV_BUSY  out  1  mult/div counter is nonzero.

Behaviour:
- Reset (asynchronous, RESET_N low):
  - All scoreboard entries invalid.
  - Mult/div counter = 0.
  - Outputs: STALL_IF, STALL_ID, BUBBLE_EX, FLUSH_ID, MULDIV_BUSY = 0; FWD_A, FWD_B = 00.
  - Reset asserted mid-stall clears everything in the same instant; no residual stall after release.
- Scoreboard entry fields: {valid, reg[4:0], load}.
  - An entry counts as a writer only if valid && reg != 0. Register 0 never causes a hazard or a forward.
- Hazard conditions (combinational, from current state and ID inputs):
  - LU (load-use): ID_VALID && EX.load && EX writer && ((ID_USE_RS && EX.reg == ID_RS) || (ID_USE_RT && EX.reg == ID_RT)).
  - HL: ID_VALID && ID_HILO && counter != 0.
  - MD: ID_VALID && ID_MULDIV && counter != 0. A second mult/div waits for the first.
  - FL: EX_BR_TAKEN || (ID_VALID && ID_IRJ[0]).
- Output priority:
  - FL wins over everything:
    - FLUSH_ID = 1, STALL_IF = 0, STALL_ID = 0.
    - BUBBLE_EX = EX_BR_TAKEN. A wrong-path ID instruction must not enter EX; a jump in ID itself proceeds.
  - Otherwise, if STALL = LU | HL | MD:
    - STALL_IF = STALL_ID = BUBBLE_EX = 1, FLUSH_ID = 0.
  - Otherwise all four are 0.
- Scoreboard advance, every clock:
  - WB <= MEM.
  - MEM <= EX.
  - EX <= {ID_VALID && ID_WEN, ID_WREG, ID_LOAD} when !BUBBLE_EX; otherwise EX <= invalid.
- Mult/div counter:
  - Loads MULDIV_CYCLES when an ID_MULDIV instruction enters EX (ID_VALID && ID_MULDIV && !BUBBLE_EX).
  - Otherwise decrements when nonzero.
  - MULDIV_BUSY = (counter != 0), registered.
  - An MFHI in ID stalls exactly MULDIV_CYCLES cycles after a back-to-back MULT.
- Forwarding, operand A (FWD_B identical using EX-stage RT):
  - Uses the source registers of the instruction currently in EX, latched from ID_RS/ID_RT with the same advance/bubble rule.
  - FWD_A = 01 if MEM writer && MEM.reg == ex_rs.
  - Else 10 if WB writer && WB.reg == ex_rs.
  - Else 00.
  - MEM priority: the youngest value wins.
  - A load in MEM is never forwarded from MEM; LU has already inserted the bubble, so the load is in WB by the time it is used.
- Latency:
  - Hazard outputs are combinational in the same cycle.
  - Scoreboard state updates one cycle later.

Optional Feature:
- Macro: HAZARD_STALL_COUNT_EN.
- When defined:
  - Adds output STALL_CNT [CNT_W-1:0], reset to 0.
  - Increments on each cycle with STALL_IF = 1; saturates at all-ones.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Load-use stall: LW $8 then ADD $9,$8,$1 -> exactly 1 cycle with STALL_IF = STALL_ID = BUBBLE_EX = 1, then FWD_A = 10 in the ADD's EX cycle.
- ALU forwarding: ADD $3,... then SUB $4,$3,$3 -> no stall; FWD_A = FWD_B = 01. Same pair with one independent instruction between them -> FWD_A = FWD_B = 10.
- Register 0: LW $0 then ADD $5,$0,$0 -> no stall, FWD_A = FWD_B = 00.
- Mult/div: MULT then MFHI with MULDIV_CYCLES = 4 -> STALL_ID high for 4 cycles, MULDIV_BUSY falls on the same edge the stall ends.
- Branch during stall: EX_BR_TAKEN = 1 while LU is active -> FLUSH_ID = 1, BUBBLE_EX = 1, STALL_IF = 0 in that cycle. J in ID -> FLUSH_ID = 1, BUBBLE_EX = 0.
- Reset mid-operation: RESET_N low during the 2nd mult/div stall cycle -> all outputs 0 immediately, MULDIV_BUSY = 0, and with HAZARD_STALL_COUNT_EN defined STALL_CNT = 0.
